conv_data_mover_tiled: RTL
==========================

// Module: conv_data_mover_tiled
// PURPOSE
//  Tile-sequenced successor of the conv data mover: per tile, loads PE_SIZE stationary weight words from
//  mem0 into the systolic array, waits a programmable settle gap, then streams cfg_rows activation
//  words from mem1 to the GLB. Repeats for cfg_tiles tiles with start/busy/done handshake and GLB backpressure.
//  Sits between the weight/activation BRAMs and the SA stationary port / GLB write port.
// PARAMETERS
//  DATA_WIDTH   128  word width of mem0, mem1 and all data outputs
//  MEM0_AW      10   mem0 address width (weights); addresses wrap modulo 2**MEM0_AW
//  MEM1_AW      10   mem1 address width (activations); addresses wrap modulo 2**MEM1_AW
//  PE_SIZE      16   weight words per tile (SA rows), >=2
//  ROW_W        8    width of cfg_rows; max rows per tile = 2**ROW_W-1
//  TILE_W       6    width of cfg_tiles
//  GAP_W        4    width of cfg_gap (settle cycles between weight load and stream)
// PORTS
//  clk          in   1        single clock, all logic on rising edge
//  rst          in   1        synchronous reset, active-high
//  start_i      in   1        pulse in IDLE: latch cfg_*, begin tile 0; ignored when busy_o=1
//  cfg_rows     in   ROW_W    activation words per tile (0 -> treated as 1)
//  cfg_tiles    in   TILE_W   tiles per job (0 -> done_o next cycle, no reads)
//  cfg_gap      in   GAP_W    settle cycles between last weight read and first activation read
//  mem0_addr0   out  MEM0_AW  weight read address
//  mem0_ce0     out  1        weight read enable
//  mem0_q0_i    in   DATA_WIDTH weight data, 1-cycle read latency
//  mem1_addr0   out  MEM1_AW  activation read address
//  mem1_ce0     out  1        activation read enable
//  mem1_q0_i    in   DATA_WIDTH activation data, 1-cycle read latency
//  w_data_o     out  DATA_WIDTH weight word to SA (= mem0_q0_i)
//  w_valid_o    out  1        mem0_ce0 delayed 1 cycle
//  w_last_o     out  1        with w_valid_o on PE_SIZE-th word of tile
//  a_data_o     out  DATA_WIDTH activation word to GLB (= mem1_q0_i)
//  a_wren_o     out  1        mem1_ce0 delayed 1 cycle
//  a_rden_o     out  1        a_wren_o delayed 1 cycle (GLB read-back strobe)
//  glb_stall_i  in   1        GLB backpressure; freezes STREAM issue
//  busy_o       out  1        high from cycle after start_i until done_o
//  done_o       out  1        1-cycle pulse after last activation a_rden_o of last tile
// BEHAVIOUR
//  - Reset: FSM=IDLE, all counters/addresses 0, every output 0; mem0/mem1 address pointers restart at 0.
//  - Reset mid-job aborts immediately; no further ce pulses; pipelined valids cleared same edge.
//  - FSM: IDLE -start_i-> LOAD_W -PE_SIZE reads-> GAP -cfg_gap cycles (0=skip)-> STREAM
//    -cfg_rows issued-> DRAIN (2 cycles, lets a_wren_o/a_rden_o flush) -> next tile LOAD_W, or DONE
//    after last tile; DONE -> IDLE after 1 cycle (done_o high in DONE).
//  - LOAD_W: mem0_ce0=1 every cycle, exactly PE_SIZE cycles; mem0 addr increments each read, persists across tiles.
//  - STREAM: mem1_ce0 = !glb_stall_i; address increments only on issued read; exactly cfg_rows
//    issues per tile; stall holds address and count, no gaps otherwise.
//  - Latency: w_valid_o/a_wren_o = ce + 1 cycle; a_rden_o = ce + 2; data outputs combinational passthrough.
//  - Address wrap: pointer at 2**AW-1 wraps to 0 on next read, no error.
//  - start_i while busy ignored; start_i same cycle as DONE ignored (accepted only in IDLE).
//  - Counters sized to full parameter width; no silent truncation of cfg values.
// STRUCTURE
//  - Package conv_dm_pkg: state enum (IDLE, LOAD_W, GAP, STREAM, DRAIN, DONE), DRAIN_CYC=2 constant.
//  - Sub-module: conv_dm_cnt (load/enable/terminal-count down-counter, param width) instantiated for
//    weight count, gap count, row count, tile count. Top holds FSM, address pointers, output pipe regs.
// TESTING
//  - Reset then start_i, cfg_tiles=1, cfg_rows=4, cfg_gap=0, PE_SIZE=16 -> mem0 addr 0..15, mem1 addr 0..3,
//    w_last_o on word 16, done_o 1 cycle after last a_rden_o, busy_o high throughout.
//  - cfg_tiles=3, cfg_rows=5, cfg_gap=3 -> mem0 addr 0..47, mem1 addr 0..14, 3-cycle gap before each stream.
//  - glb_stall_i asserted 4 cycles mid-STREAM -> mem1_ce0 low those cycles, address held, 5 rows still delivered.
//  - MEM1_AW=3, cfg_rows=10 -> mem1 addr 0..7,0,1; no X, done_o normal.
//  - rst asserted during STREAM -> next cycle all outputs 0, FSM IDLE; new start_i runs from addr 0.
//  - cfg_tiles=0 -> no ce pulses, done_o one cycle after start; start_i during busy_o -> no effect.

Source files
------------

// File: rtl/conv_data_mover_tiled_pkg.sv
// Shared types for the tiled conv data mover.
// FSM state encoding and drain length.
package conv_dm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    GAP,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  localparam int DRAIN_CYC = 2;

endpackage

// File: rtl/conv_data_mover_tiled_if.sv
// Bus bundle for the tiled conv data mover.
// Job handshake/config, mem0/mem1 read ports, SA weight and GLB ports.
interface conv_data_mover_tiled_if #(
  parameter int DATA_WIDTH = 128,
  parameter int MEM0_AW    = 10,
  parameter int MEM1_AW    = 10,
  parameter int ROW_W      = 8,
  parameter int TILE_W     = 6,
  parameter int GAP_W      = 4
);
  logic                  start_i;
  logic [ROW_W-1:0]      cfg_rows;
  logic [TILE_W-1:0]     cfg_tiles;
  logic [GAP_W-1:0]      cfg_gap;
  logic [MEM0_AW-1:0]    mem0_addr0;
  logic                  mem0_ce0;
  logic [DATA_WIDTH-1:0] mem0_q0_i;
  logic [MEM1_AW-1:0]    mem1_addr0;
  logic                  mem1_ce0;
  logic [DATA_WIDTH-1:0] mem1_q0_i;
  logic [DATA_WIDTH-1:0] w_data_o;
  logic                  w_valid_o;
  logic                  w_last_o;
  logic [DATA_WIDTH-1:0] a_data_o;
  logic                  a_wren_o;
  logic                  a_rden_o;
  logic                  glb_stall_i;
  logic                  busy_o;
  logic                  done_o;

  modport master (
    input  start_i, cfg_rows, cfg_tiles, cfg_gap,
    input  mem0_q0_i, mem1_q0_i, glb_stall_i,
    output mem0_addr0, mem0_ce0, mem1_addr0, mem1_ce0,
    output w_data_o, w_valid_o, w_last_o,
    output a_data_o, a_wren_o, a_rden_o,
    output busy_o, done_o
  );

  modport slave (
    output start_i, cfg_rows, cfg_tiles, cfg_gap,
    output mem0_q0_i, mem1_q0_i, glb_stall_i,
    input  mem0_addr0, mem0_ce0, mem1_addr0, mem1_ce0,
    input  w_data_o, w_valid_o, w_last_o,
    input  a_data_o, a_wren_o, a_rden_o,
    input  busy_o, done_o
  );
endinterface

// File: rtl/conv_data_mover_tiled_cnt.sv
// Loadable down-counter with terminal-count flag.
// Ports: clk, rst, ld_i/ld_val_i (load), en_i (decrement), tc_o (count==0).
module conv_dm_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_val_i,
  input  logic             en_i,
  output logic             tc_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i)
      cnt_d = ld_val_i;
    else if (en_i && cnt_q != '0)
      cnt_d = cnt_q - WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/conv_data_mover_tiled.sv
// Tiled weight-load / activation-stream mover for the systolic array.
// Ports: clk, rst, bus (start/cfg, mem0/mem1 reads, SA + GLB outputs).
module conv_data_mover_tiled
  import conv_dm_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int MEM0_AW    = 10,
  parameter int MEM1_AW    = 10,
  parameter int PE_SIZE    = 16,
  parameter int ROW_W      = 8,
  parameter int TILE_W     = 6,
  parameter int GAP_W      = 4
) (
  input logic clk,
  input logic rst,
  conv_data_mover_tiled_if.master bus
);
  localparam int WCW = $clog2(PE_SIZE);
  localparam logic [WCW-1:0] W_LAST = WCW'(PE_SIZE - 1);

  state_e state_q, state_d;
  logic [ROW_W-1:0]   rows_q, rows_src, rows_ld;
  logic [GAP_W-1:0]   gap_q, gap_src;
  logic [MEM0_AW-1:0] a0_q;
  logic [MEM1_AW-1:0] a1_q;
  logic [1:0]         drn_q;
  logic w_valid_q, w_last_q, a_wren_q, a_rden_q;
  logic go, tile_ld, w_ce, a_ce, drn_last;
  logic w_tc, g_tc, r_tc, t_tc;

  assign go       = (state_q == IDLE) && bus.start_i;
  assign drn_last = (drn_q == 2'(DRAIN_CYC - 1));
  assign w_ce     = (state_q == LOAD_W);
  assign a_ce     = (state_q == STREAM) && !bus.glb_stall_i;
  // Per-tile counters reload at job start and at each tile boundary.
  assign tile_ld  = (go && bus.cfg_tiles != '0)
                  || (state_q == DRAIN && drn_last && !t_tc);
  assign rows_src = (state_q == IDLE) ? bus.cfg_rows : rows_q;
  assign gap_src  = (state_q == IDLE) ? bus.cfg_gap : gap_q;
  // Zero rows behaves as one row.
  assign rows_ld  = (rows_src == '0) ? '0 : rows_src - ROW_W'(1);

  conv_dm_cnt #(.WIDTH(WCW)) u_wcnt (
    .clk(clk), .rst(rst), .ld_i(tile_ld),
    .ld_val_i(W_LAST), .en_i(w_ce), .tc_o(w_tc)
  );

  conv_dm_cnt #(.WIDTH(GAP_W)) u_gcnt (
    .clk(clk), .rst(rst), .ld_i(tile_ld),
    .ld_val_i(gap_src - GAP_W'(1)),
    .en_i(state_q == GAP), .tc_o(g_tc)
  );

  conv_dm_cnt #(.WIDTH(ROW_W)) u_rcnt (
    .clk(clk), .rst(rst), .ld_i(tile_ld),
    .ld_val_i(rows_ld), .en_i(a_ce), .tc_o(r_tc)
  );

  conv_dm_cnt #(.WIDTH(TILE_W)) u_tcnt (
    .clk(clk), .rst(rst), .ld_i(go),
    .ld_val_i(bus.cfg_tiles - TILE_W'(1)),
    .en_i(state_q == DRAIN && drn_last), .tc_o(t_tc)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (bus.start_i)
          state_d = (bus.cfg_tiles == '0) ? DONE : LOAD_W;
      LOAD_W:
        if (w_tc) state_d = (gap_q == '0) ? STREAM : GAP;
      GAP:
        if (g_tc) state_d = STREAM;
      STREAM:
        if (a_ce && r_tc) state_d = DRAIN;
      DRAIN:
        if (drn_last) state_d = t_tc ? DONE : LOAD_W;
      DONE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rows_q    <= '0;
      gap_q     <= '0;
      a0_q      <= '0;
      a1_q      <= '0;
      drn_q     <= '0;
      w_valid_q <= 1'b0;
      w_last_q  <= 1'b0;
      a_wren_q  <= 1'b0;
      a_rden_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (go) begin
        rows_q <= bus.cfg_rows;
        gap_q  <= bus.cfg_gap;
      end
      if (w_ce) a0_q <= a0_q + MEM0_AW'(1);
      if (a_ce) a1_q <= a1_q + MEM1_AW'(1);
      if (state_q == DRAIN && !drn_last)
        drn_q <= drn_q + 2'd1;
      else
        drn_q <= '0;
      w_valid_q <= w_ce;
      w_last_q  <= w_ce && w_tc;
      a_wren_q  <= a_ce;
      a_rden_q  <= a_wren_q;
    end
  end

  assign bus.mem0_addr0 = a0_q;
  assign bus.mem0_ce0   = w_ce;
  assign bus.mem1_addr0 = a1_q;
  assign bus.mem1_ce0   = a_ce;
  // Data is masked outside valid so every output is 0 after reset.
  assign bus.w_data_o  = w_valid_q ? bus.mem0_q0_i : {DATA_WIDTH{1'b0}};
  assign bus.w_valid_o = w_valid_q;
  assign bus.w_last_o  = w_last_q;
  assign bus.a_data_o  = a_wren_q ? bus.mem1_q0_i : {DATA_WIDTH{1'b0}};
  assign bus.a_wren_o  = a_wren_q;
  assign bus.a_rden_o  = a_rden_q;
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.done_o    = (state_q == DONE);
endmodule
